// File: rtl/gf233_mul_sched_if.sv
// Bundles the sequencer handshake (start/a/b/busy/done/c) and the shared
// multiplier-core link (m_a/m_b/m_valid/m_d) for gf233_mul_sched.
interface gf233_mul_sched_if;
    logic         start;
    logic [232:0] a;
    logic [232:0] b;
    logic         busy;
    logic         done;
    logic [232:0] c;
    logic [58:0]  m_a;
    logic [58:0]  m_b;
    logic         m_valid;
    logic [117:0] m_d;

    modport slave (
        input  start, a, b, m_d,
        output busy, done, c, m_a, m_b, m_valid
    );

    modport master (
        output start, a, b, m_d,
        input  busy, done, c, m_a, m_b, m_valid
    );
endinterface

// File: rtl/gf233_mul_sched.sv
// GF(2^233) multiplier controller: streams 16 limb pairs through a shared 59x59
// carry-less core, accumulates the 465-bit product, then folds twice mod x^233+x^74+1.
module gf233_mul_sched #(
    parameter int unsigned MULT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    gf233_mul_sched_if.slave  bus
);

    localparam int unsigned ACC_W = 472;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FOLD1,
        FOLD2
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] shift;
    } tag_t;

    state_t             state_q, state_d;
    logic [232:0]       a_q, a_d;
    logic [232:0]       b_q, b_d;
    logic [3:0]         k_q, k_d;
    logic [2:0]         drain_q, drain_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [232:0]       c_q, c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [58:0]        m_a_q, m_a_d;
    logic [58:0]        m_b_q, m_b_d;
    logic               m_valid_q, m_valid_d;
    logic [2:0]         shift_q, shift_d;
    tag_t               tag_q [MULT_LAT+1];
    tag_t               tag_d [MULT_LAT+1];

    tag_t               tag_out;
    logic [8:0]         shamt;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   acc_cap;
    logic [ACC_W-1:0]   acc_fold;
    logic [3:0]         k_n;

    function automatic logic [58:0] limb(input logic [232:0] v, input logic [1:0] idx);
        logic [235:0] ext;
        logic [58:0]  r;
        ext = {3'b000, v};
        case (idx)
            2'd0:    r = ext[58:0];
            2'd1:    r = ext[117:59];
            2'd2:    r = ext[176:118];
            default: r = ext[235:177];
        endcase
        return r;
    endfunction

    // x^233 == x^74 + 1: the high part H re-enters at bit 0 and at bit 74.
    function automatic logic [ACC_W-1:0] fold(input logic [ACC_W-1:0] v);
        logic [231:0]     h;
        logic [ACC_W-1:0] hx;
        h  = v[464:233];
        hx = {{(ACC_W-232){1'b0}}, h};
        return {{(ACC_W-233){1'b0}}, v[232:0]} ^ hx ^ (hx << 74);
    endfunction

    always_comb begin
        // tag_q[0] rides alongside the pair on m_a/m_b; tag_q[MULT_LAT] lines up with m_d.
        tag_out  = tag_q[MULT_LAT];
        shamt    = 9'(tag_out.shift) * 9'd59;
        prod_ext = {{(ACC_W-118){1'b0}}, bus.m_d} << shamt;
        acc_cap  = acc_q ^ (tag_out.vld ? prod_ext : '0);
        acc_fold = fold(acc_q);
        k_n      = k_q + 4'd1;

        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        k_d       = k_q;
        drain_d   = drain_q;
        acc_d     = acc_cap;
        c_d       = c_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        m_a_d     = m_a_q;
        m_b_d     = m_b_q;
        m_valid_d = m_valid_q;
        shift_d   = shift_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    acc_d     = '0;
                    k_d       = '0;
                    busy_d    = 1'b1;
                    m_a_d     = limb(bus.a, 2'd0);
                    m_b_d     = limb(bus.b, 2'd0);
                    m_valid_d = 1'b1;
                    shift_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (k_q == 4'd15) begin
                    m_valid_d = 1'b0;
                    m_a_d     = '0;
                    m_b_d     = '0;
                    shift_d   = '0;
                    drain_d   = '0;
                    state_d   = (MULT_LAT == 0) ? FOLD1 : DRAIN;
                end else begin
                    k_d       = k_n;
                    m_a_d     = limb(a_q, k_n[3:2]);
                    m_b_d     = limb(b_q, k_n[1:0]);
                    shift_d   = {1'b0, k_n[3:2]} + {1'b0, k_n[1:0]};
                    m_valid_d = 1'b1;
                end
            end
            DRAIN: begin
                if ({29'b0, drain_q} + 32'd1 >= MULT_LAT) begin
                    state_d = FOLD1;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            FOLD1: begin
                acc_d   = acc_fold;
                state_d = FOLD2;
            end
            FOLD2: begin
                acc_d   = acc_fold;
                c_d     = acc_fold[232:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tag_d    = tag_q;
        tag_d[0] = {m_valid_d, shift_d};
        for (int unsigned i = 1; i <= MULT_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            acc_q     <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            m_valid_q <= 1'b0;
            shift_q   <= '0;
            tag_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            acc_q     <= acc_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
            m_valid_q <= m_valid_d;
            shift_q   <= shift_d;
            tag_q     <= tag_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.c       = c_q;
    assign bus.m_a     = m_a_q;
    assign bus.m_b     = m_b_q;
    assign bus.m_valid = m_valid_q;

endmodule

// File: tb/tb_gf233_mul_sched.sv
// Scoreboard bench for gf233_mul_sched: one instance with a combinational core,
// one with a 3-cycle core that returns garbage outside valid product slots.
module tb_gf233_mul_sched;

    typedef struct {
        logic [232:0] c;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0_n;
    logic rst3_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t q0[$];
    exp_t q3[$];

    logic [117:0] p1, p2;
    logic         v1, v2;
    logic [127:0] garb;

    gf233_mul_sched_if if0();
    gf233_mul_sched_if if3();

    gf233_mul_sched #(.MULT_LAT(0)) dut0 (.clk(clk), .rst_n(rst0_n), .bus(if0));
    gf233_mul_sched #(.MULT_LAT(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [117:0] clmul(input logic [58:0] x, input logic [58:0] y);
        logic [117:0] r;
        r = '0;
        for (int i = 0; i < 59; i++) begin
            if (y[i]) r = r ^ ({59'b0, x} << i);
        end
        return r;
    endfunction

    // Horner-style bit-serial multiply with reduction after every shift.
    function automatic logic [232:0] ref_mul(input logic [232:0] x, input logic [232:0] y);
        logic [233:0] r;
        r = '0;
        for (int i = 232; i >= 0; i--) begin
            r = r << 1;
            if (r[233]) begin
                r[233] = 1'b0;
                r[74]  = ~r[74];
                r[0]   = ~r[0];
            end
            if (y[i]) r[232:0] = r[232:0] ^ x;
        end
        return r[232:0];
    endfunction

    always_comb if0.m_d = clmul(if0.m_a, if0.m_b);

    always @(posedge clk) begin
        garb   <= {$urandom(), $urandom(), $urandom(), $urandom()};
        p1     <= clmul(if3.m_a, if3.m_b);
        v1     <= if3.m_valid;
        p2     <= p1;
        v2     <= v1;
        if3.m_d <= v2 ? p2 : garb[117:0];
    end

    task automatic check(input string name, input logic [232:0] got, input logic [232:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic check_pop(input int inst, input logic [232:0] got);
        exp_t e;
        total++;
        if ((inst == 0 && q0.size() == 0) || (inst == 3 && q3.size() == 0)) begin
            bad++;
            $display("FAIL done%0d: unexpected done at cycle %0d, required none", inst, cyc);
        end else begin
            if (inst == 0) e = q0.pop_front();
            else           e = q3.pop_front();
            if (got !== e.c) begin
                bad++;
                $display("FAIL c%0d: got %h required %h", inst, got, e.c);
            end
            total++;
            if (cyc != e.cyc) begin
                bad++;
                $display("FAIL latency%0d: done at cycle %0d required %0d", inst, cyc, e.cyc);
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (if0.done) check_pop(0, if0.c);
            if (if3.done) check_pop(3, if3.c);
        end
    endtask

    // Called at a negedge (cycle T); returns at the negedge of T+1.
    task automatic start_op(input int inst, input logic [232:0] av, input logic [232:0] bv,
                            input logic [232:0] ec, input bit push);
        exp_t e;
        e.c   = ec;
        e.cyc = cyc + 19 + ((inst == 3) ? 3 : 0);
        if (inst == 0) begin
            if0.start = 1'b1; if0.a = av; if0.b = bv;
            if (push) q0.push_back(e);
        end else begin
            if3.start = 1'b1; if3.a = av; if3.b = bv;
            if (push) q3.push_back(e);
        end
        @(negedge clk);
        if (inst == 0) if0.start = 1'b0;
        else           if3.start = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget);
        int n;
        n = 0;
        while (!((inst == 0) ? if0.done : if3.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!((inst == 0) ? if0.done : if3.done)) begin
            total++;
            bad++;
            $display("FAIL wait_done%0d: no done within %0d cycles, required done", inst, budget);
        end
    endtask

    task automatic check_windows(input int inst, input int lat);
        for (int n = 1; n <= 19 + lat; n++) begin
            logic bsy, mv;
            bsy = (inst == 0) ? if0.busy : if3.busy;
            mv  = (inst == 0) ? if0.m_valid : if3.m_valid;
            check($sformatf("busy%0d@T+%0d", inst, n), 233'(bsy), 233'(n <= 18 + lat));
            check($sformatf("m_valid%0d@T+%0d", inst, n), 233'(mv), 233'(n <= 16));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [232:0] one, x232, av, bv;
        logic [255:0] r;

        one  = 233'd1;
        x232 = one << 232;
        if0.start = 1'b0; if0.a = '0; if0.b = '0;
        if3.start = 1'b0; if3.a = '0; if3.b = '0;
        rst0_n = 1'b0;
        rst3_n = 1'b0;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        rst3_n = 1'b1;

        check("rst busy0",    233'(if0.busy),    '0);
        check("rst done0",    233'(if0.done),    '0);
        check("rst c0",       if0.c,             '0);
        check("rst m_a0",     233'(if0.m_a),     '0);
        check("rst m_b0",     233'(if0.m_b),     '0);
        check("rst m_valid0", 233'(if0.m_valid), '0);
        check("rst busy3",    233'(if3.busy),    '0);
        check("rst done3",    233'(if3.done),    '0);
        check("rst c3",       if3.c,             '0);
        check("rst m_valid3", 233'(if3.m_valid), '0);

        fork
            monitor();
        join_none

        // 1 * 1, with busy/m_valid windows
        start_op(0, one, one, one, 1'b1);
        check_windows(0, 0);

        // x^232 * x = x^74 + 1, then back-to-back x^232 * x^232 = x^231 + x^146 + x^72
        start_op(0, x232, 233'd2, (one << 74) | one, 1'b1);
        wait_done(0, 40);
        start_op(0, x232, x232, (one << 231) | (one << 146) | (one << 72), 1'b1);
        wait_done(0, 40);
        @(negedge clk);

        // start while busy is ignored: (x^5+1)*x^3 = x^8+x^3
        start_op(0, 233'h21, 233'h8, 233'h108, 1'b1);
        repeat (4) @(negedge clk);
        start_op(0, 233'h3, 233'h3, 233'h5, 1'b0);
        wait_done(0, 40);
        repeat (30) @(negedge clk);

        // reset at T+10 aborts the operation
        start_op(0, 233'h7, 233'h7, 233'h15, 1'b0);
        repeat (9) @(negedge clk);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        check("abort busy",    233'(if0.busy),    '0);
        check("abort c",       if0.c,             '0);
        check("abort m_valid", 233'(if0.m_valid), '0);
        check("abort done",    233'(if0.done),    '0);
        repeat (30) @(negedge clk);
        start_op(0, 233'h7, 233'h7, 233'h15, 1'b1);
        wait_done(0, 40);
        @(negedge clk);

        // MULT_LAT=3: x^100 * x^200 = x^300 = x^141 + x^67
        start_op(3, one << 100, one << 200, (one << 141) | (one << 67), 1'b1);
        check_windows(3, 3);

        for (int i = 0; i < 200; i++) begin
            r  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            av = r[232:0];
            r  = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            bv = r[232:0];
            start_op(3, av, bv, ref_mul(av, bv), 1'b1);
            wait_done(3, 60);
        end

        repeat (30) @(negedge clk);
        check("q0 drained", 233'(q0.size()), '0);
        check("q3 drained", 233'(q3.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
